// File: rtl/dmem_pkg.sv
`default_nettype none
// dmem_pkg: shared MemLen encodings, arbiter FSM states and length helpers
// for the MEM-stage data-memory arbiter.
package dmem_pkg;

  localparam logic [2:0] LEN_B  = 3'd0;
  localparam logic [2:0] LEN_H  = 3'd1;
  localparam logic [2:0] LEN_W  = 3'd2;
  localparam logic [2:0] LEN_BU = 3'd3;
  localparam logic [2:0] LEN_HU = 3'd4;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic logic is_legal_len(input logic [2:0] len);
    return (len == LEN_B) || (len == LEN_H) || (len == LEN_W) ||
           (len == LEN_BU) || (len == LEN_HU);
  endfunction

  // The memory write path only decodes byte/half/word, so unsigned
  // store lengths collapse onto their signed twins.
  function automatic logic [2:0] store_len(input logic [2:0] len);
    logic [2:0] res;
    res = len;
    if (len == LEN_BU) res = LEN_B;
    if (len == LEN_HU) res = LEN_H;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// dmem_arb_pick: combinational winner selection between the core (port 0)
// and the loader (port 1), for fixed-priority or round-robin policy.
module dmem_arb_pick
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WW       = 3
) (
  input  logic          mode,
  input  logic          req0,
  input  logic          req1,
  input  logic          last_grant,
  input  logic [WW-1:0] wait_cnt,
  input  state_t        state,
  output logic          sel,
  output logic          grant_valid
);

  logic starved;
  assign starved = (wait_cnt == WW'(MAX_WAIT));

  always_comb begin
    sel         = 1'b0;
    grant_valid = req0 | req1;
    if (state == ST_LOCK) begin
      sel         = 1'b1;
      grant_valid = req1;
    end else if (mode) begin
      sel = (req0 && req1) ? ~last_grant : req1;
    end else begin
      // Port 1 only overrides port 0 once it has waited MAX_WAIT cycles.
      sel = req1 && (!req0 || starved);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port data
// memory; steers 1-cycle read data back to the issuing port, supports a lock.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = 8,
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [2:0]    len0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [31:0]   rdata0,
  output logic          rerr0,
  input  logic          req1,
  input  logic          we1,
  input  logic [2:0]    len1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [31:0]   rdata1,
  output logic          rerr1,
  input  logic          lock1,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_in,
  output logic [2:0]    mem_len,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_ce,
  input  logic [31:0]   mem_out
);

  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_t        state, state_nx, arb_state;
  logic          last_grant;
  logic [WW-1:0] wait_cnt;
  logic          sel, grant_valid;

  logic          win_we, win_legal;
  logic [2:0]    win_len;
  logic [AW-1:0] win_addr;
  logic [31:0]   win_wdata;

  logic          rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
  logic [31:0]   hold0, hold1;

  // The cycle lock1 drops is already arbitrated as a normal ARB cycle.
  assign arb_state = (state == ST_LOCK && lock1) ? ST_LOCK : ST_ARB;

  dmem_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .WW       (WW)
  ) u_pick (
    .mode        (ARB_MODE != 0),
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .wait_cnt    (wait_cnt),
    .state       (arb_state),
    .sel         (sel),
    .grant_valid (grant_valid)
  );

  assign win_we    = sel ? we1    : we0;
  assign win_len   = sel ? len1   : len0;
  assign win_addr  = sel ? addr1  : addr0;
  assign win_wdata = sel ? wdata1 : wdata0;
  assign win_legal = is_legal_len(win_len);

  always_comb begin
    gnt0      = grant_valid & ~sel;
    gnt1      = grant_valid & sel;
    mem_addr  = '0;
    mem_in    = 32'h0;
    mem_len   = 3'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_ce    = 1'b0;
    if (grant_valid) begin
      mem_addr  = win_addr;
      mem_in    = win_wdata;
      mem_len   = win_we ? store_len(win_len) : win_len;
      // An illegal length is consumed without touching memory.
      mem_ce    = win_legal;
      mem_read  = win_legal & ~win_we;
      mem_write = win_legal & win_we;
    end
    state_nx = (arb_state == ST_LOCK || (gnt1 && lock1)) ? ST_LOCK : ST_ARB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ARB;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_err0   <= 1'b0;
      rsp_err1   <= 1'b0;
      hold0      <= 32'h0;
      hold1      <= 32'h0;
    end else begin
      if (grant_valid) last_grant <= sel;
      if (!req1 || gnt1)                    wait_cnt <= '0;
      else if (wait_cnt != WW'(MAX_WAIT))   wait_cnt <= wait_cnt + WW'(1);
      rsp_valid0 <= gnt0 & ~we0;
      rsp_valid1 <= gnt1 & ~we1;
      rsp_err0   <= gnt0 & ~is_legal_len(len0);
      rsp_err1   <= gnt1 & ~is_legal_len(len1);
      if (rsp_valid0) hold0 <= rdata0;
      if (rsp_valid1) hold1 <= rdata1;
    end
  end

  assign rvalid0 = rsp_valid0;
  assign rvalid1 = rsp_valid1;
  assign rerr0   = rsp_err0;
  assign rerr1   = rsp_err1;
  // Live memory data in the response cycle, last response held afterwards.
  assign rdata0  = rsp_valid0 ? (rsp_err0 ? 32'h0 : mem_out) : hold0;
  assign rdata1  = rsp_valid1 ? (rsp_err1 ? 32'h0 : mem_out) : hold1;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory in the MEM stage.
- Shares the memory between port 0, the core MEM stage, and port 1, the debug/program loader.
- Selects a winner each cycle, drives the memory control signals, and steers the 1-cycle-latency read data back to the port that issued the read.
- Supports an exclusive lock so the loader can own memory for a burst, and bounds port-1 starvation.

Parameters:
- AW, 8: memory byte-address width.
- ARB_MODE, 0: arbitration policy. 0 = fixed priority to port 0 with anti-starvation; 1 = round-robin.
- MAX_WAIT, 4: consecutive denied cycles of port 1 before it is force-granted (ARB_MODE 0 only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request.
- we0  in  1  port 0 write (1) / read (0).
- len0  in  3  port 0 MemLen: 0 = sb/lb, 1 = sh/lh, 2 = word, 3 = lbu, 4 = lhu.
- addr0  in  AW  port 0 byte address.
- wdata0  in  32  port 0 store data.
- gnt0  out  1  port 0 request accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  32  port 0 read data.
- rerr0  out  1  port 0 access had an illegal length.
- req1, we1, len1, addr1, wdata1, gnt1, rvalid1, rdata1, rerr1: same as port 0, for port 1.
- lock1  in  1  port 1 requests exclusive ownership.
- mem_addr  out  AW  to memory addr.
- mem_in  out  32  to memory in.
- mem_len  out  3  to memory MemLen.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_ce  out  1  to memory CE.
- mem_out  in  32  registered memory read data, valid the cycle after the read is issued.

Behaviour:
- Reset (rst_n low, asynchronous): FSM = ARB, last_grant = 1, wait_cnt = 0, response registers cleared. rvalid0/1, rerr0/1 and rdata0/1 = 0. mem_* outputs follow the combinational rule below, so with no grant they are 0.
- Grant is combinational in cycle T; the memory samples at the end of T. At most one gnt per cycle.
- mem_* are 0 when no grant. With a grant, mem_* = winner's fields, mem_ce = 1, mem_read = ~we, mem_write = we.
- Store length remap: a store with len 3 is driven as mem_len 0, len 4 as mem_len 1. The memory write path decodes only 0/1/2.
- Illegal len 5..7: the request is granted (it is consumed), mem_ce = 0.
  - Read: rvalid = 1 and rerr = 1 in T+1, rdata = 0.
  - Write: no memory effect, rerr = 1 in T+1.
- Read response: rvalid of the granted port = 1 in T+1, rdata = mem_out. rdata holds its value until the next response to that port. Back-to-back grants are allowed every cycle; full throughput is 1 access/cycle.
- Writes give no rvalid; gnt is the completion.
- FSM ARB, ARB_MODE 0:
  - Port 0 wins if req0, except when wait_cnt == MAX_WAIT and req1; then port 1 wins.
  - wait_cnt increments when req1 && !gnt1 and saturates at MAX_WAIT; it clears on gnt1 or when !req1.
- FSM ARB, ARB_MODE 1: if both request, the port ≠ last_grant wins. last_grant updates on every grant.
- ARB -> LOCK: when gnt1 && lock1.
- FSM LOCK: gnt0 = 0, and port 1 is granted whenever req1. LOCK -> ARB on the first cycle lock1 = 0; that cycle is already arbitrated as ARB.
- Port 0 in LOCK: requests are held off; the requester must keep its signals stable while req0 && !gnt0.
- Reset mid-burst or with a read outstanding: the response is discarded (no rvalid after reset) and the FSM returns to ARB.
- lock1 asserted without req1: no effect in ARB.

Decomposition:
- Shared package dmem_pkg: MemLen constants (LEN_B = 0, LEN_H = 1, LEN_W = 2, LEN_BU = 3, LEN_HU = 4), FSM state encoding (ST_ARB, ST_LOCK), and a function is_legal_len.
- One sub-module is natural: dmem_arb_pick. It is the combinational winner selection from req0, req1, mode, last_grant, wait_cnt and state, and outputs sel and grant_valid.
- The response pipeline and FSM stay in the top.

Test Plan:
- Port 0 read only, len 2 at addr 0x10 on reset-initialised memory: gnt0 in T; rvalid0 in T+1 with rdata0 = 0x13121110; port 1 outputs idle.
- Both request every cycle, ARB_MODE 0, MAX_WAIT 4: gnt0 for 4 cycles, gnt1 on cycle 5, wait_cnt back to 0, then the pattern repeats.
- Both request, ARB_MODE 1: grants alternate 0, 1, 0, 1; each read's rvalid lands on the issuing port one cycle later with the correct data.
- lock1 = 1 with port 1 writing words to addr 0x00, 0x04, 0x08 while req0 is held: gnt0 = 0 throughout; lock1 drops -> gnt0 in that cycle; a port-0 read of 0x04 returns the written word.
- Port 0 store len 3 at addr 0x21 with wdata 0xAB: mem_len = 0, mem_write = 1; a later len 3 read of 0x21 returns 0x000000AB. Port 0 len 6 read: gnt0, mem_ce = 0, rvalid0 = rerr0 = 1 next cycle, rdata0 = 0.
- Assert rst_n low the cycle after a granted read: rvalid0 stays 0, all response outputs are 0, FSM = ARB after rst_n releases.
